// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game timing blocks.
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int unsigned BCD_W          = 4;
    localparam int unsigned TIME_LIMIT_DEF = 60;
    localparam int unsigned WARN_AT_DEF    = 50;

    function automatic logic [6:0] bcd_to_bin(input logic [BCD_W-1:0] tens,
                                              input logic [BCD_W-1:0] units);
        return 7'(tens * 10) + 7'(units);
    endfunction

endpackage

// File: rtl/bcd_sec_counter.sv
// Two-digit BCD seconds counter, 00..99, synchronous clear over increment.
module bcd_sec_counter
    import snake_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] units
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens  <= '0;
            units <= '0;
        end else if (clr) begin
            tens  <= '0;
            units <= '0;
        end else if (inc) begin
            if (units == BCD_W'(9)) begin
                units <= '0;
                tens  <= (tens == BCD_W'(9)) ? '0 : tens + 1'b1;
            end else begin
                units <= units + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_timer_ctrl.sv
// Run-control sequencer: one-second prescaler, BCD elapsed-time counter,
// and warning/time-limit flags for the snake game.
module game_timer_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned TIME_LIMIT = TIME_LIMIT_DEF,
    parameter int unsigned WARN_AT    = WARN_AT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause_tgl,
    input  logic       game_over,
    output logic [7:0] time_bcd,
    output logic [1:0] state,
    output logic       running,
    output logic       warn,
    output logic       expired,
    output logic       timeout_pulse
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t           cur, nxt;
    logic [PW-1:0]    pres;
    logic [BCD_W-1:0] tens, units;
    logic [6:0]       secs;
    logic             advance, sec_tick, limit_hit, inc, clr;
    logic             expired_nxt, pulse_nxt;

    assign secs = bcd_to_bin(tens, units);

    // The cycle that samples pause_tgl in RUN is not a counting cycle.
    assign advance   = (cur == RUN) && !pause_tgl;
    assign sec_tick  = advance && (pres == PW'(TICK_DIV - 1));
    assign limit_hit = sec_tick && (secs == 7'(TIME_LIMIT - 1));
    assign inc       = sec_tick && !game_over;

    always_comb begin
        nxt         = cur;
        clr         = 1'b0;
        expired_nxt = expired;
        pulse_nxt   = 1'b0;
        case (cur)
            IDLE: begin
                if (start) begin
                    nxt = RUN;
                    clr = 1'b1;
                end
            end
            RUN: begin
                if (game_over) begin
                    nxt         = DONE;
                    expired_nxt = 1'b0;
                end else if (limit_hit) begin
                    nxt         = DONE;
                    expired_nxt = 1'b1;
                    pulse_nxt   = 1'b1;
                end else if (pause_tgl) begin
                    nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (game_over) begin
                    nxt         = DONE;
                    expired_nxt = 1'b0;
                end else if (pause_tgl) begin
                    nxt = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    nxt         = RUN;
                    clr         = 1'b1;
                    expired_nxt = 1'b0;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur           <= IDLE;
            expired       <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            cur           <= nxt;
            expired       <= expired_nxt;
            timeout_pulse <= pulse_nxt;
        end
    end

    // Held rather than cleared outside RUN so a paused partial second survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres <= '0;
        end else if (clr) begin
            pres <= '0;
        end else if (advance) begin
            pres <= (pres == PW'(TICK_DIV - 1)) ? '0 : pres + 1'b1;
        end
    end

    bcd_sec_counter u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc),
        .tens  (tens),
        .units (units)
    );

    assign time_bcd = {tens, units};
    assign state    = cur;
    assign running  = (cur == RUN);
    assign warn     = (cur != IDLE) && (secs >= 7'(WARN_AT));

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Randomized plus directed bench for game_timer_ctrl against a seconds-level model.
module tb_game_timer_ctrl;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned TIME_LIMIT = 12;
    localparam int unsigned WARN_AT    = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, pause_tgl = 1'b0, game_over = 1'b0;
    logic [7:0] time_bcd;
    logic [1:0] state;
    logic       running, warn, expired, timeout_pulse;

    int checks = 0;
    int failures = 0;

    // Reference model: 0=IDLE 1=RUN 2=PAUSE 3=DONE, whole seconds plus run cycles into the current second.
    int m_state = 0, m_secs = 0, m_frac = 0;
    bit m_exp = 0, m_pulse = 0;

    game_timer_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .TIME_LIMIT (TIME_LIMIT),
        .WARN_AT    (WARN_AT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .pause_tgl     (pause_tgl),
        .game_over     (game_over),
        .time_bcd      (time_bcd),
        .state         (state),
        .running       (running),
        .warn          (warn),
        .expired       (expired),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_secs = 0; m_frac = 0; m_exp = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit g);
        m_pulse = 0;
        case (m_state)
            0: if (s) begin m_state = 1; m_secs = 0; m_frac = 0; end
            1: begin
                if (g) begin
                    m_state = 3; m_exp = 0;
                end else if (p) begin
                    m_state = 2;
                end else begin
                    m_frac++;
                    if (m_frac == TICK_DIV) begin
                        m_frac = 0;
                        m_secs++;
                        if (m_secs == TIME_LIMIT) begin
                            m_state = 3; m_exp = 1; m_pulse = 1;
                        end
                    end
                end
            end
            2: begin
                if (g) begin m_state = 3; m_exp = 0; end
                else if (p) m_state = 1;
            end
            default: if (s) begin m_state = 1; m_secs = 0; m_frac = 0; m_exp = 0; end
        endcase
    endtask

    task automatic check_all();
        logic [7:0] exp_bcd;
        exp_bcd = {4'(m_secs / 10), 4'(m_secs % 10)};
        check("state", 32'(state), 32'(m_state));
        check("time_bcd", 32'(time_bcd), 32'(exp_bcd));
        check("running", 32'(running), 32'(m_state == 1));
        check("warn", 32'(warn), 32'(m_secs >= WARN_AT && m_state != 0));
        check("expired", 32'(expired), 32'(m_exp));
        check("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
    endtask

    task automatic step(input bit s, input bit p, input bit g);
        start = s; pause_tgl = p; game_over = g;
        @(posedge clk);
        model_step(s, p, g);
        #1;
        check_all();
        start = 0; pause_tgl = 0; game_over = 0;
    endtask

    task automatic run_to_secs(input int target);
        int n = 0;
        while (m_secs != target && n < 200) begin
            step(0, 0, 0);
            n++;
        end
        check("run_to_secs_bound", 32'(m_secs), 32'(target));
    endtask

    task automatic async_reset();
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 check_all();
        #2 rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        bit s, p, g;
        #3;
        model_reset();
        check_all();
        #10 rst_n = 1;
        @(negedge clk);

        // Ignored pause in IDLE, then a full round to the time limit.
        step(0, 1, 0);
        step(1, 0, 0);
        n = 0;
        while (m_state != 3 && n < 100) begin step(0, 0, 0); n++; end
        check("limit_state", 32'(state), 32'd3);
        check("limit_bcd", 32'(time_bcd), 32'h12);
        repeat (3) step(0, 0, 0);

        // Pause two cycles into a second, hold 20 cycles, resume.
        step(1, 0, 0);
        run_to_secs(1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        repeat (20) step(0, 0, 0);
        step(0, 1, 0);
        repeat (6) step(0, 0, 0);

        // Start ignored at 05; game_over in PAUSE at 07; restart.
        run_to_secs(5);
        step(1, 0, 0);
        run_to_secs(7);
        step(0, 1, 0);
        step(0, 0, 1);
        check("go_pause_bcd", 32'(time_bcd), 32'h07);
        step(0, 0, 0);
        step(1, 0, 0);
        check("restart_bcd", 32'(time_bcd), 32'h00);

        // game_over on the tick that would reach the limit.
        n = 0;
        while (!(m_secs == 11 && m_frac == TICK_DIV - 1) && n < 200) begin step(0, 0, 0); n++; end
        step(0, 0, 1);
        check("go_tick_bcd", 32'(time_bcd), 32'h11);
        check("go_tick_expired", 32'(expired), 32'd0);
        repeat (3) step(0, 0, 0);

        // Async reset mid-round at 09, then no counting until start.
        step(1, 0, 0);
        run_to_secs(9);
        step(0, 0, 0);
        async_reset();
        repeat (8) step(0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 19) == 0);
            p = ($urandom_range(0, 14) == 0);
            g = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 599) == 0) async_reset();
            else step(s, p, g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_timer_ctrl.md
# game_timer_ctrl

Run-control sequencer for the snake game's elapsed-time counter. Owns a 1-second tick prescaler and a two-digit BCD seconds counter. Starts, pauses, resumes and stops them from game-level events. Flags the warning window and the round time limit to the LED/LCD display and game-logic blocks.

## Interface

**Parameters**
- `TICK_DIV`, default 1000: clk cycles per one-second tick. Range 2..2^26.
- `TIME_LIMIT`, default 60: seconds at which the round expires. Range 1..99.
- `WARN_AT`, default 50: seconds at or above which `warn` is asserted. Must be below `TIME_LIMIT`.

**Ports**
- Clocking and reset (already decided): reset `rst_n`, asynchronous, active-low; clock `clk`.
- `start`, in, 1: single-cycle pulse; begin a new round.
- `pause_tgl`, in, 1: single-cycle pulse; toggle pause.
- `game_over`, in, 1: single-cycle pulse from snake logic (collision).
- `time_bcd`, out, 8: {tens[3:0], units[3:0]} elapsed seconds, BCD.
- `state`, out, 2: current FSM state.
- `running`, out, 1: 1 only in RUN.
- `warn`, out, 1: 1 when elapsed seconds ≥ `WARN_AT` and state ≠ IDLE.
- `expired`, out, 1: level; 1 in DONE if the round ended by time limit, 0 if it ended by `game_over`.
- `timeout_pulse`, out, 1: one-cycle pulse on the edge that enters DONE via the time limit.

## Operation

**States:** IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11.

**Transitions**
- IDLE, `start` → RUN.
- RUN, `pause_tgl` → PAUSE.
- PAUSE, `pause_tgl` → RUN.
- RUN or PAUSE, `game_over` → DONE, with `expired`=0.
- RUN, limit reached → DONE, with `expired`=1.
- DONE, `start` → RUN (new round).

**Input priority when simultaneous:** `game_over` > limit reached > `start` > `pause_tgl`.
- A `start` in RUN/PAUSE is ignored.
- A `pause_tgl` in IDLE/DONE is ignored.

**Prescaler**
- Counts 0..`TICK_DIV`-1 only in RUN and wraps to 0.
- The wrap cycle produces the internal `sec_tick`.
- Held (not cleared) in PAUSE, so the partial second is preserved.

**Seconds counter**
- Increments on `sec_tick`. Units 0..9 carry into tens 0..9.
- "Limit reached" = `sec_tick` while the count equals `TIME_LIMIT`-1. The counter still increments to `TIME_LIMIT` and freezes there in DONE.

**Clearing**
- Entering RUN from IDLE or DONE clears the prescaler and the seconds count to 0 on that same edge.
- On a `game_over` exit, `time_bcd` holds its final value in DONE.

**`game_over` and `sec_tick` in the same cycle:** go to DONE, `expired`=0, and the seconds count does NOT increment.

**Reset (asynchronous, any time including mid-round)**
- state=IDLE, `time_bcd`=8'h00, `running`=0, `warn`=0, `expired`=0, `timeout_pulse`=0.
- Prescaler = 0.

## Timing

- All outputs are registered, with no combinational input-to-output path.
- `start` sampled at edge N: `state`=RUN and `running`=1 after edge N, and `time_bcd`=00.
- With no pause, `time_bcd` becomes 01 after edge N+`TICK_DIV`, and k seconds after edge N+k·`TICK_DIV`.
- A pause of P cycles delays all later increments by exactly P cycles. The toggle cycles themselves count as non-RUN cycles: the cycle where `pause_tgl` is sampled in RUN does not advance the prescaler.
- `timeout_pulse`, `expired`=1, `state`=DONE and `time_bcd`=`TIME_LIMIT` (BCD) all update on the same edge.
- `warn` updates on the same edge as `time_bcd`.

## Structure

**Shared package `snake_pkg`**
- State enum/localparams (IDLE/RUN/PAUSE/DONE).
- BCD digit width constant (4).
- `TIME_LIMIT`/`WARN_AT` defaults.

**Sub-module `bcd_sec_counter`**
- Inputs: `clk`, `rst_n`, `clr`, `inc`.
- Outputs: `tens`, `units`.
- 2-digit BCD with synchronous clear (clear has priority over inc).

**Top level:** the FSM, the prescaler, limit/warn compare, and output registers.

## Test plan

Bench uses `TICK_DIV`=4, `TIME_LIMIT`=12, `WARN_AT`=10.

1. Reset release, then `start` → `running`=1 next cycle. `time_bcd` steps 00, 01, … every 4 cycles. At 10, `warn`=1. At 12, `timeout_pulse` for 1 cycle, `expired`=1, `state`=11, count frozen at 8'h12.
2. Start, then `pause_tgl` 2 cycles into a second, wait 20 cycles, then `pause_tgl` again → `time_bcd` unchanged during pause. Next increment comes after the remaining partial second, with total elapsed RUN cycles per second = 4.
3. `game_over` at count 07 in PAUSE → DONE, `expired`=0, no `timeout_pulse`, `time_bcd` held at 8'h07. Then `start` → `time_bcd`=00, state RUN.
4. `game_over` coincident with the `sec_tick` taking 11→12 → DONE, `expired`=0, `timeout_pulse`=0, `time_bcd`=8'h11.
5. Ignored inputs: `start` pulse in RUN at count 05 → no clear. `pause_tgl` in IDLE → stays IDLE.
6. Assert `rst_n`=0 asynchronously mid-round at count 09 → all outputs 0 and state IDLE without a clock edge. After release, no counting until `start`.
